// File: rtl/game_state_pkg.sv
// Shared types and limits for the Flappy Bird game-flow controller.
//   game_state_t : session state encoding driven on game_flow_controller.state
//   LIVES_MAX    : largest supported lives-per-game value
//   TICKS_MIN    : smallest supported countdown / grace duration in frames
//   max_int      : elaboration helper used to size the shared phase counter
package game_state_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COUNTDOWN = 3'd1,
    RUNNING   = 3'd2,
    GRACE     = 3'd3,
    PAUSED    = 3'd4,
    OVER      = 3'd5
  } game_state_t;

  localparam int LIVES_MAX = 15;
  localparam int TICKS_MIN = 1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rise_edge.sv
// Registered rising-edge detector for a level button input.
//   clk   : system clock
//   reset : asynchronous active-low reset (clears the registered copy)
//   d     : level input
//   rise  : high for the cycle in which d is 1 and its registered copy is 0
// A held input yields exactly one rise. Because the copy resets to 0, an input
// already high on the first cycle after reset release counts as an edge.
module rise_edge (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) d_q <= 1'b0;
    else        d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/game_flow_controller.sv
// Game-flow state machine: session lifecycle, lives, countdown and grace timing.
//   clk        : system clock
//   reset      : asynchronous active-low reset
//   tick       : one-cycle frame strobe; timed phases advance only on it
//   collision  : level, bird overlaps pipe or ground
//   up         : level, flap/start button (used as rising edge)
//   pause      : level, pause button (used as rising edge)
//   state      : current game_state_t
//   running    : RUNNING or GRACE
//   done       : IDLE or OVER
//   grace      : GRACE
//   lives_left : remaining lives
//   life_lost  : one-cycle pulse, coincident with the decremented lives_left
//
// state     | meaning
// IDLE      | waiting for start after reset
// COUNTDOWN | frames left before play, collisions ignored
// RUNNING   | world scrolling, collisions cost a life
// GRACE     | post-hit immunity, world still scrolling
// PAUSED    | everything frozen, remembers RUNNING or GRACE
// OVER      | lives exhausted, waiting for restart
module game_flow_controller
  import game_state_pkg::*;
#(
  parameter int LIVES           = 3,
  parameter int COUNTDOWN_TICKS = 60,
  parameter int GRACE_TICKS     = 90,
  parameter int LIVES_W         = $clog2(LIVES + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               collision,
  input  logic               up,
  input  logic               pause,
  output logic [2:0]         state,
  output logic               running,
  output logic               done,
  output logic               grace,
  output logic [LIVES_W-1:0] lives_left,
  output logic               life_lost
);

  if (LIVES < 1 || LIVES > LIVES_MAX ||
      COUNTDOWN_TICKS < TICKS_MIN || GRACE_TICKS < TICKS_MIN) begin : g_bad_cfg
    $error("game_flow_controller: illegal LIVES / COUNTDOWN_TICKS / GRACE_TICKS");
  end

  // One counter serves both timed phases, so it is sized for the longer one.
  localparam int CNT_W = $clog2(max_int(COUNTDOWN_TICKS, GRACE_TICKS) + 1);

  localparam logic [CNT_W-1:0]   CNT_COUNTDOWN = CNT_W'(COUNTDOWN_TICKS);
  localparam logic [CNT_W-1:0]   CNT_GRACE     = CNT_W'(GRACE_TICKS);
  localparam logic [CNT_W-1:0]   CNT_ONE       = CNT_W'(1);
  localparam logic [LIVES_W-1:0] LIVES_INIT    = LIVES_W'(LIVES);
  localparam logic [LIVES_W-1:0] LIVES_ONE     = LIVES_W'(1);

  game_state_t        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic               ret_grace_q, ret_grace_d;
  logic               life_lost_d;
  logic               up_rise, pause_rise;

  rise_edge u_up_edge (
    .clk   (clk),
    .reset (reset),
    .d     (up),
    .rise  (up_rise)
  );

  rise_edge u_pause_edge (
    .clk   (clk),
    .reset (reset),
    .d     (pause),
    .rise  (pause_rise)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q       <= '0;
      lives_q     <= LIVES_INIT;
      ret_grace_q <= 1'b0;
      life_lost   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      lives_q     <= lives_d;
      ret_grace_q <= ret_grace_d;
      life_lost   <= life_lost_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lives_d     = lives_q;
    ret_grace_d = ret_grace_q;
    life_lost_d = 1'b0;
    case (state_q)
      IDLE, OVER: begin
        if (up_rise) begin
          lives_d = LIVES_INIT;
          cnt_d   = CNT_COUNTDOWN;
          state_d = COUNTDOWN;
        end
      end
      COUNTDOWN: begin
        if (tick) begin
          // Leave on the tick that takes the count to zero.
          if (cnt_q > CNT_ONE) begin
            cnt_d = cnt_q - CNT_ONE;
          end else begin
            cnt_d   = '0;
            state_d = RUNNING;
          end
        end
      end
      RUNNING: begin
        if (collision && (lives_q != '0)) begin
          lives_d     = lives_q - LIVES_ONE;
          life_lost_d = 1'b1;
          if (lives_q == LIVES_ONE) begin
            state_d = OVER;
          end else begin
            cnt_d   = CNT_GRACE;
            state_d = GRACE;
          end
        end else if (pause_rise) begin
          ret_grace_d = 1'b0;
          state_d     = PAUSED;
        end
      end
      GRACE: begin
        if (pause_rise) begin
          ret_grace_d = 1'b1;
          state_d     = PAUSED;
        end else if (tick) begin
          if (cnt_q > CNT_ONE) begin
            cnt_d = cnt_q - CNT_ONE;
          end else begin
            cnt_d   = '0;
            state_d = RUNNING;
          end
        end
      end
      PAUSED: begin
        if (pause_rise) state_d = ret_grace_q ? GRACE : RUNNING;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    state      = state_q;
    running    = (state_q == RUNNING) || (state_q == GRACE);
    done       = (state_q == IDLE) || (state_q == OVER);
    grace      = (state_q == GRACE);
    lives_left = lives_q;
  end

endmodule

// File: tb/tb_game_flow_controller.sv
module tb_game_flow_controller;
  import game_state_pkg::*;

  localparam int LIVES = 3;
  localparam int CD    = 4;
  localparam int GR    = 5;
  localparam int LW    = $clog2(LIVES + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          tick = 1'b0;
  logic          collision = 1'b0;
  logic          up = 1'b0;
  logic          pause = 1'b0;
  logic [2:0]    state;
  logic          running, done, grace, life_lost;
  logic [LW-1:0] lives_left;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  game_flow_controller #(
    .LIVES           (LIVES),
    .COUNTDOWN_TICKS (CD),
    .GRACE_TICKS     (GR)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .collision  (collision),
    .up         (up),
    .pause      (pause),
    .state      (state),
    .running    (running),
    .done       (done),
    .grace      (grace),
    .lives_left (lives_left),
    .life_lost  (life_lost)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: phase, lives, frames remaining, and where a pause returns to.
  game_state_t m_state = IDLE;
  game_state_t m_ret   = IDLE;
  int          m_lives = LIVES;
  int          m_frames = 0;
  int          m_lost  = 0;
  bit          p_up = 1'b0, p_pause = 1'b0;

  always @(posedge clk or negedge reset) begin
    bit up_e, pause_e;
    if (!reset) begin
      m_state = IDLE; m_ret = IDLE; m_lives = LIVES; m_frames = 0; m_lost = 0;
      p_up = 1'b0; p_pause = 1'b0;
    end else begin
      up_e    = up && !p_up;
      pause_e = pause && !p_pause;
      p_up    = up;
      p_pause = pause;
      m_lost  = 0;
      case (m_state)
        IDLE, OVER:
          if (up_e) begin
            m_lives = LIVES; m_frames = CD; m_state = COUNTDOWN;
          end
        COUNTDOWN:
          if (tick) begin
            m_frames--;
            if (m_frames == 0) m_state = RUNNING;
          end
        RUNNING:
          if (collision) begin
            m_lives--; m_lost = 1;
            if (m_lives == 0) m_state = OVER;
            else begin m_frames = GR; m_state = GRACE; end
          end else if (pause_e) begin
            m_ret = RUNNING; m_state = PAUSED;
          end
        GRACE:
          if (pause_e) begin
            m_ret = GRACE; m_state = PAUSED;
          end else if (tick) begin
            m_frames--;
            if (m_frames == 0) m_state = RUNNING;
          end
        PAUSED:
          if (pause_e) m_state = m_ret;
        default: m_state = IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("state",      int'(state),      int'(m_state));
      chk("running",    int'(running),    int'(m_state == RUNNING || m_state == GRACE));
      chk("done",       int'(done),       int'(m_state == IDLE || m_state == OVER));
      chk("grace",      int'(grace),      int'(m_state == GRACE));
      chk("lives_left", int'(lives_left), m_lives);
      chk("life_lost",  int'(life_lost),  m_lost);
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // Reset state
    cyc(2);
    chk_en = 1'b1;
    chk("rst_state", int'(state), int'(IDLE));
    chk("rst_done", int'(done), 1);
    chk("rst_lives", int'(lives_left), LIVES);
    chk("rst_life_lost", int'(life_lost), 0);

    // Up-edge on the first cycle after release starts the countdown
    reset = 1'b1; up = 1'b1;
    cyc();
    up = 1'b0;
    chk("start_state", int'(state), int'(COUNTDOWN));
    chk("start_lives", int'(lives_left), 3);
    for (int i = 1; i <= CD; i++) begin
      tick = 1'b1; cyc(); tick = 1'b0;
      chk("cd_state", int'(state), (i < CD) ? int'(COUNTDOWN) : int'(RUNNING));
      cyc(2);
    end
    chk("cd_running", int'(running), 1);

    // First hit: lives 3 -> 2, pulse, GRACE
    collision = 1'b1; cyc(); collision = 1'b0;
    chk("hit1_state", int'(state), int'(GRACE));
    chk("hit1_lives", int'(lives_left), 2);
    chk("hit1_pulse", int'(life_lost), 1);
    chk("model_lives", m_lives, 2);
    cyc();
    chk("hit1_pulse_end", int'(life_lost), 0);

    // Two ticks leave 3 grace frames, then pause through 20 ticks
    repeat (2) begin tick = 1'b1; cyc(); tick = 1'b0; cyc(); end
    pause = 1'b1; cyc(); pause = 1'b0;
    chk("pause_state", int'(state), int'(PAUSED));
    repeat (20) begin tick = 1'b1; cyc(); tick = 1'b0; cyc(); end
    chk("paused_hold", int'(state), int'(PAUSED));
    chk("paused_running", int'(running), 0);
    pause = 1'b1; cyc(); pause = 1'b0;
    chk("resume_state", int'(state), int'(GRACE));
    for (int i = 1; i <= 3; i++) begin
      tick = 1'b1; cyc(); tick = 1'b0;
      chk("resume_tick", int'(state), (i < 3) ? int'(GRACE) : int'(RUNNING));
      cyc();
    end

    // Collision + pause-edge + tick together: collision wins
    collision = 1'b1; pause = 1'b1; tick = 1'b1;
    cyc();
    collision = 1'b0; pause = 1'b0; tick = 1'b0;
    chk("simul_state", int'(state), int'(GRACE));
    chk("simul_lives", int'(lives_left), 1);
    chk("model_simul", int'(m_state), int'(GRACE));

    // Collision held through GRACE costs the last life on the first RUNNING cycle
    collision = 1'b1;
    for (int i = 1; i <= GR; i++) begin
      tick = 1'b1; cyc(); tick = 1'b0;
      if (i < GR) begin
        chk("held_grace", int'(grace), 1);
        cyc();
      end else begin
        chk("held_exit", int'(state), int'(RUNNING));
      end
    end
    cyc();
    collision = 1'b0;
    chk("over_state", int'(state), int'(OVER));
    chk("over_done", int'(done), 1);
    chk("over_lives", int'(lives_left), 0);
    chk("over_pulse", int'(life_lost), 1);
    cyc(3);
    chk("over_hold_lives", int'(lives_left), 0);

    // Held up restarts exactly once
    up = 1'b1; cyc(10); up = 1'b0;
    chk("restart_state", int'(state), int'(COUNTDOWN));
    chk("restart_lives", int'(lives_left), LIVES);

    // Async reset while PAUSED takes effect before the next clock edge
    repeat (CD) begin tick = 1'b1; cyc(); tick = 1'b0; end
    pause = 1'b1; cyc(); pause = 1'b0;
    chk("pre_rst_state", int'(state), int'(PAUSED));
    #2 reset = 1'b0;
    #1;
    chk("async_state", int'(state), int'(IDLE));
    chk("async_lives", int'(lives_left), LIVES);
    chk("async_pulse", int'(life_lost), 0);
    cyc();
    reset = 1'b1;

    // Randomised play against the model
    for (int n = 0; n < 4000; n++) begin
      tick = ($urandom_range(0, 3) == 0);
      if (collision) collision = ($urandom_range(0, 2) != 0);
      else           collision = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 9) == 0)  up = ~up;
      if ($urandom_range(0, 11) == 0) pause = ~pause;
      if ($urandom_range(0, 1499) == 0) reset = 1'b0;
      cyc();
      reset = 1'b1;
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/game_flow_controller.md
# game_flow_controller

Parametrised game-flow state machine for the Flappy Bird core. It tracks the full session lifecycle: idle, start countdown, running, post-hit grace, pause, and game over. It keeps a multi-life counter and drives the `done`/`running` qualifiers consumed by the bird physics, pipe scroller and score logic. Timed phases advance only on the frame `tick` strobe, so durations are expressed in frames.

## Interface
Parameters:
- LIVES, 3: lives granted per game; legal range 1..15
- COUNTDOWN_TICKS, 60: frames spent in COUNTDOWN before RUNNING; must be ≥1
- GRACE_TICKS, 90: frames of collision immunity after a non-fatal hit; must be ≥1
- LIVES_W, $clog2(LIVES+1): width of the lives bus (derived, not overridden)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle frame strobe
- collision  in  1  level; bird overlaps pipe or ground
- up  in  1  level; flap/start button
- pause  in  1  level; pause button
- state  out  3  current state, encoded as game_state_t
- running  out  1  high in RUNNING or GRACE (world scrolls)
- done  out  1  high in IDLE or OVER
- grace  out  1  high in GRACE (bird drawn blinking)
- lives_left  out  LIVES_W  remaining lives
- life_lost  out  1  one-cycle pulse per life decrement

## Operation
- `up` and `pause` are used only as rising edges, detected internally against a registered copy. Holding a button produces exactly one event.
- States and transitions (evaluated every clk):
  - IDLE: on up-edge, load lives_left=LIVES, load countdown counter, go to COUNTDOWN.
  - COUNTDOWN: decrement on tick. On the tick that reaches 0, go to RUNNING. Collision is ignored.
  - RUNNING: collision → lives_left−1 and pulse life_lost. If the new value is 0, go to OVER. Otherwise load the grace counter and go to GRACE. A pause-edge with no collision goes to PAUSED and records the return state.
  - GRACE: collision is ignored. Decrement on tick; at 0, go to RUNNING. A pause-edge goes to PAUSED.
  - PAUSED: counters frozen, tick ignored. A pause-edge returns to the saved state (RUNNING or GRACE) with its counter value intact.
  - OVER: on up-edge, same action as from IDLE: reload lives and enter COUNTDOWN.
- Priority within one cycle: collision > pause-edge > tick.
- A collision held high across the GRACE→RUNNING transition costs a life on the first RUNNING cycle.
- lives_left never underflows. It holds its value in OVER and changes only on reload or a RUNNING collision.
- Outputs `done`, `running`, `grace` and `state` are Moore decodes of the state register. `life_lost` is registered.

## Timing
- Reset (reset=0, asynchronous): state=IDLE, done=1, running=0, grace=0, lives_left=LIVES, life_lost=0, counters=0, edge registers=0.
- Reset release needs no extra cycles; an up-edge on the first cycle after release is honoured.
- Transition latency is one clk: the input is sampled at edge N, and the new state and outputs are visible after edge N.
- COUNTDOWN lasts exactly COUNTDOWN_TICKS tick strobes. RUNNING is entered on the clk edge that samples the final tick.
- GRACE works the same way with GRACE_TICKS.
- life_lost is high for exactly the one cycle following the sampled collision, coincident with the decremented lives_left.
- Reset asserted mid-game aborts from any state to IDLE immediately, with no pulse on life_lost.

## Structure
- Package game_state_pkg:
  - typedef enum logic [2:0] game_state_t {IDLE, COUNTDOWN, RUNNING, GRACE, PAUSED, OVER}
  - max-parameter limit constants
- Sub-module rise_edge: 1-bit registered rising-edge detector with async active-low reset. It is instantiated twice, for up and pause.
- One shared down-counter sized $clog2(max(COUNTDOWN_TICKS, GRACE_TICKS)+1). It is reused by COUNTDOWN and GRACE and frozen in PAUSED.

## Test plan
- Start and countdown:
  - Stimulus: reset low then high, up pulse, COUNTDOWN_TICKS=4, tick every 3 cycles.
  - Required: state IDLE→COUNTDOWN; RUNNING on the 4th tick edge; lives_left=3.
- Life loss and grace:
  - Stimulus: in RUNNING, one-cycle collision; GRACE_TICKS=5; collision held through GRACE.
  - Required: lives_left=2 and one life_lost pulse; grace=1 for 5 ticks; then lives_left=1 on the first RUNNING cycle.
- Game over and restart:
  - Stimulus: LIVES=1, collision in RUNNING.
  - Required: OVER, done=1, lives_left=0.
  - Follow-up: up held high for 10 cycles gives a single COUNTDOWN entry with lives_left=1.
- Pause:
  - Stimulus: pause-edge in GRACE with counter=3, 20 ticks while PAUSED, pause-edge again.
  - Required: returns to GRACE with counter=3; exactly 3 more ticks to RUNNING.
- Simultaneous events:
  - Stimulus: collision, pause-edge and tick in the same RUNNING cycle with lives=2.
  - Required: GRACE, lives_left=1, not PAUSED.
- Async reset:
  - Stimulus: reset asserted between clk edges while in PAUSED.
  - Required: IDLE and lives_left=LIVES immediately, before the next clk edge.
